// File: rtl/partial_scan_harness.sv
// partial_scan_harness: serial stimulus/capture wrapper around a flattened partial-extract module.
// Shifts a vector in LSB-first, applies it in parallel, waits LAT edges, captures and shifts the response out.
`default_nettype none

module partial_scan_harness #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 5,
  parameter int LAT   = 2
) (
  input  logic              CLK,
  input  logic              ASYNCRESET,
  input  logic              start,
  input  logic              si,
  output logic [N_IN-1:0]   pin,
  input  logic [N_OUT-1:0]  pout,
  output logic              so,
  output logic              busy,
  output logic              done
);

  localparam int MAX_IO = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam int MAXV   = (MAX_IO > LAT) ? MAX_IO : LAT;
  localparam int CW     = $clog2(MAXV + 1);

  localparam logic [CW-1:0] IN_LAST  = CW'(N_IN - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(N_OUT - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_APPLY     = 3'd2,
    S_SHIFT_OUT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  // Bit 0 of the input shift register would be shifted out on the load edge
  // anyway, so only the upper N_IN-1 bits are kept; the load edge appends si.
  logic [N_IN-2:0]     in_sr;
  logic [N_OUT-1:0]    out_sr;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      in_sr  <= '0;
      out_sr <= '0;
      pin    <= '0;
      so     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt  <= '0;
          so   <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state <= S_SHIFT_IN;
            busy  <= 1'b1;
          end
        end

        S_SHIFT_IN: begin
          in_sr <= {si, in_sr[N_IN-2:1]};
          if (cnt == IN_LAST) begin
            pin   <= {si, in_sr};
            cnt   <= '0;
            state <= S_APPLY;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_APPLY: begin
          if (cnt == LAT_LAST) begin
            out_sr <= pout;
            so     <= pout[0];
            cnt    <= '0;
            state  <= S_SHIFT_OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // so is a registered copy of out_sr[0] while shifting out
        S_SHIFT_OUT: begin
          out_sr <= {1'b0, out_sr[N_OUT-1:1]};
          if (cnt == OUT_LAST) begin
            so    <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            so  <= out_sr[1];
            cnt <= cnt + CW'(1);
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          so    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_partial_scan_harness.sv
// tb_partial_scan_harness: directed vector table plus hand sequences for back-to-back,
// ignored start and asynchronous reset, across LAT = 2, 3 and 1 instances.
`default_nettype none

module tb_partial_scan_harness;

  logic clk;
  logic rst;
  logic si;
  logic [2:0] start_v;
  logic [2:0] busy_v, so_v, done_v;
  logic [6:0] pin0, pin1, pin2;
  logic [4:0] pout0, pout1, pout2;
  logic       mode0;
  logic [4:0] ff0a, ff0b, ff1a, ff1b;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LAT = 2 instance: loopback of pin[4:0] or through two external flops
  partial_scan_harness #(.N_IN(7), .N_OUT(5), .LAT(2)) dut0 (
    .CLK(clk), .ASYNCRESET(rst), .start(start_v[0]), .si(si),
    .pin(pin0), .pout(pout0), .so(so_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );
  // LAT = 3 instance: always through two external flops
  partial_scan_harness #(.N_IN(7), .N_OUT(5), .LAT(3)) dut1 (
    .CLK(clk), .ASYNCRESET(rst), .start(start_v[1]), .si(si),
    .pin(pin1), .pout(pout1), .so(so_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );
  // LAT = 1 instance: small combinational partial module (O1 = ~I0)
  partial_scan_harness #(.N_IN(7), .N_OUT(5), .LAT(1)) dut2 (
    .CLK(clk), .ASYNCRESET(rst), .start(start_v[2]), .si(si),
    .pin(pin2), .pout(pout2), .so(so_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff0a <= '0; ff0b <= '0; ff1a <= '0; ff1b <= '0;
    end else begin
      ff0a <= pin0[4:0]; ff0b <= ff0a;
      ff1a <= pin1[4:0]; ff1b <= ff1a;
    end
  end

  assign pout0 = mode0 ? ff0b : pin0[4:0];
  assign pout1 = ff1b;
  assign pout2 = {1'b0, pin2[6], pin2[2] & pin2[3], ~pin2[0], pin2[0] ^ pin2[1]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] pin_of(input int d);
    if (d == 0) return pin0;
    if (d == 1) return pin1;
    return pin2;
  endfunction

  // One transaction on instance d; sample index e means "cycle after edge e", e0 = start edge.
  task automatic run_txn(input int d, input int lat, input logic [6:0] stim,
                         input logic [4:0] exp_cap, input int poke_e);
    int last;
    int ndone;
    logic [4:0] cap;
    logic so_bad, busy_bad, done_bad;
    last = 7 + lat + 5;
    ndone = 0; cap = '0; so_bad = 1'b0; busy_bad = 1'b0; done_bad = 1'b0;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int e = 1; e <= last + 3; e++) begin
      if (e <= 7) si = stim[e-1];
      else si = 1'($urandom_range(0, 1));
      start_v[d] = (e == poke_e);
      @(posedge clk);
      @(negedge clk);
      if (e == 7) chk($sformatf("pin_load d%0d", d), 32'(pin_of(d)), 32'(stim));
      if (e >= 7 + lat && e < 7 + lat + 5) cap[e-7-lat] = so_v[d];
      else if (so_v[d] !== 1'b0) so_bad = 1'b1;
      if (done_v[d] === 1'b1) ndone++;
      if (done_v[d] !== (e == last)) done_bad = 1'b1;
      if (busy_v[d] !== (e <= last)) busy_bad = 1'b1;
    end
    start_v[d] = 1'b0;
    chk($sformatf("capture d%0d", d), 32'(cap), 32'(exp_cap));
    chk($sformatf("done_count d%0d", d), ndone, 1);
    chk($sformatf("done_timing d%0d", d), 32'(done_bad), 0);
    chk($sformatf("so_idle_zero d%0d", d), 32'(so_bad), 0);
    chk($sformatf("busy_profile d%0d", d), 32'(busy_bad), 0);
    chk($sformatf("pin_hold d%0d", d), 32'(pin_of(d)), 32'(stim));
  endtask

  typedef struct {
    int         d;
    int         lat;
    logic       mode;
    logic [6:0] stim;
    logic [4:0] cap;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic done_bad, busy_bad;
    checks = 0; failures = 0;
    start_v = '0; si = 1'b0; mode0 = 1'b0;

    vecs[0] = '{0, 2, 1'b0, 7'h53, 5'h13};
    vecs[1] = '{0, 2, 1'b0, 7'h2A, 5'h0A};
    vecs[2] = '{0, 2, 1'b0, 7'h7F, 5'h1F};
    vecs[3] = '{0, 2, 1'b0, 7'h00, 5'h00};
    vecs[4] = '{0, 2, 1'b1, 7'h1F, 5'h00};  // flops deliver the previous pin
    vecs[5] = '{0, 2, 1'b1, 7'h35, 5'h1F};
    vecs[6] = '{1, 3, 1'b0, 7'h1F, 5'h1F};  // LAT 3 reaches through both flops
    vecs[7] = '{1, 3, 1'b0, 7'h35, 5'h15};
    vecs[8] = '{2, 1, 1'b0, 7'h02, 5'h03};  // I0 = 0 -> O1 = 1
    vecs[9] = '{2, 1, 1'b0, 7'h4D, 5'h0D};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pin", 32'(pin0), 0);
    chk("reset_so", 32'(so_v[0]), 0);
    chk("reset_busy", 32'(busy_v), 0);
    chk("reset_done", 32'(done_v), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      mode0 = vecs[i].mode;
      run_txn(vecs[i].d, vecs[i].lat, vecs[i].stim, vecs[i].cap, -1);
    end

    // start pulse during SHIFT_OUT is ignored and not queued
    mode0 = 1'b0;
    run_txn(0, 2, 7'h53, 5'h13, 11);

    // held start: transactions every 16 edges, done after e14 and e30
    done_bad = 1'b0; busy_bad = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int c = 0; c <= 33; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[0] !== (c == 14 || c == 30)) done_bad = 1'b1;
      if (busy_v[0] !== !(c == 15 || c == 31)) busy_bad = 1'b1;
    end
    start_v[0] = 1'b0;
    chk("b2b_done", 32'(done_bad), 0);
    chk("b2b_busy", 32'(busy_bad), 0);
    repeat (25) @(negedge clk);

    // asynchronous reset during SHIFT_IN after 3 bits
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    si = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_v[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_busy", 32'(busy_v[0]), 0);
    chk("rst_async_pin", 32'(pin0), 0);
    chk("rst_async_so", 32'(so_v[0]), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_no_done", 32'(done_v[0]), 0);
    rst = 1'b0;
    run_txn(0, 2, 7'h2A, 5'h0A, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
